// File: rtl/data_memory_pipelined_if.sv
// Wishbone classic data-bus bundle: 32-bit word data with four byte-lane selects.
interface wb_bus;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic        cyc;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport slave (
      input  addr, wdata, sel, we, stb, cyc,
      output rdata, ack, err
   );

   modport master (
      output addr, wdata, sel, we, stb, cyc,
      input  rdata, ack, err
   );
endinterface

// File: rtl/data_memory_pipelined.sv
// Wishbone-slave word SRAM with byte-lane writes, read-before-write return data,
// registered error response and an optional post-reset zeroing engine.
module data_memory_pipelined #(
   parameter logic [31:0] BaseAddr     = 32'h3000,
   parameter int unsigned DepthWords   = 1024,
   parameter bit          ClearOnReset = 1'b1
) (
   input  logic  clk_in,
   input  logic  reset_in,
   wb_bus.slave  bus_slave,
   output logic  init_done_out
);

   localparam int unsigned     AW        = $clog2(DepthWords);
   localparam logic [31:0]     SizeBytes = 32'(DepthWords * 4);
   localparam logic [AW-1:0]   LastIdx   = AW'(DepthWords - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [31:0]   r_mem [DepthWords];
   logic [AW-1:0] r_clr_cnt;
   logic          r_ack;
   logic          r_err;
   logic          r_init_done;
   logic [31:0]   r_rdata;

   logic [31:0]   w_off;
   logic [AW-1:0] w_index;
   logic          w_misaligned;
   logic          w_out_of_range;
   logic          w_req;
   logic          w_clr_last;
   logic          w_ack_next;
   logic          w_err_next;
   logic          w_rd_en;
   logic          w_wr_en;
   logic          w_clr_en;

   // Wrapping subtraction folds addresses below BaseAddr into the out-of-range test.
   assign w_off          = bus_slave.addr - BaseAddr;
   assign w_misaligned   = bus_slave.addr[1:0] != 2'b00;
   assign w_out_of_range = w_off >= SizeBytes;
   assign w_index        = w_off[AW+1:2];
   assign w_req          = bus_slave.cyc & bus_slave.stb;
   assign w_clr_last     = r_clr_cnt == LastIdx;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_ack_next   = 1'b0;
      w_err_next   = 1'b0;
      w_rd_en      = 1'b0;
      w_wr_en      = 1'b0;
      w_clr_en     = 1'b0;
      case (r_state)
         CLEAR: begin
            w_clr_en = 1'b1;
            if (w_clr_last) w_state_next = IDLE;
         end
         IDLE: begin
            if (w_req) begin
               w_state_next = RESP;
               if (w_misaligned || w_out_of_range) begin
                  w_err_next = 1'b1;
               end else begin
                  w_ack_next = 1'b1;
                  w_rd_en    = 1'b1;
                  w_wr_en    = bus_slave.we;
               end
            end
         end
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_in) begin
      if (reset_in) r_state <= ClearOnReset ? CLEAR : IDLE;
      else          r_state <= w_state_next;
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_init_done <= 1'b0;
         r_clr_cnt   <= '0;
      end else begin
         r_ack <= w_ack_next;
         r_err <= w_err_next;
         if (w_rd_en)  r_rdata   <= r_mem[w_index];
         if (w_clr_en) r_clr_cnt <= r_clr_cnt + 1'b1;
         if ((w_clr_en && w_clr_last) || !ClearOnReset) r_init_done <= 1'b1;
      end
   end

   // NOTE: the array has no reset branch; only the clear engine zeroes it, which keeps it RAM-mappable.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         if (w_clr_en) begin
            r_mem[r_clr_cnt] <= '0;
         end else if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
               if (bus_slave.sel[i]) r_mem[w_index][8*i +: 8] <= bus_slave.wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus_slave.ack   = r_ack;
   assign bus_slave.err   = r_err;
   assign bus_slave.rdata = r_rdata;
   assign init_done_out   = r_init_done;

endmodule

// File: doc/data_memory_pipelined.md
# data_memory_pipelined

Parametrised Wishbone-slave word-addressed SRAM that replaces the fixed 4 KiB data RAM on the SoC data bus. It adds configurable depth and base address, direct byte-lane writes with read-before-write return data, and a registered error response for misaligned and out-of-range accesses. It also provides an optional post-reset hardware clear engine that zeroes the array before the bus is served.

## Interface
Parameters:
- BaseAddr, 32'h3000, byte address of word 0; must be a multiple of DepthWords*4.
- DepthWords, 1024, number of 32-bit words; power of two, ≥ 2. AW = $clog2(DepthWords).
- ClearOnReset, 1'b1, when 1 the array is zeroed after every reset; when 0 contents are untouched and the block goes straight to IDLE.

Ports:
- clk_in  input  1  single clock, all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- bus_slave  wb_bus.slave  —  addr[31:0], wdata[31:0], sel[3:0], we, stb, cyc in; rdata[31:0], ack, err out.
- init_done_out  output  1  high once the clear engine has finished (or immediately after reset when ClearOnReset=0).

## Operation
- Decode: off = addr − BaseAddr (32-bit wrap arithmetic). Misaligned when addr[1:0] ≠ 0. Out of range when off ≥ DepthWords*4 (covers addr < BaseAddr via wrap). Index = off[AW+1:2].
- States: CLEAR, IDLE, RESP.
- CLEAR: entered from reset when ClearOnReset=1. A counter starts at 0 and writes 32'h0 to one word per cycle. After writing word DepthWords−1 the state moves to IDLE and init_done_out is set. Bus requests are not acknowledged during CLEAR; ack and err stay 0, so the master stalls.
- IDLE, on cyc&stb:
  - Misaligned or out of range: err←1, state→RESP; no array access, rdata unchanged.
  - Otherwise: ack←1, rdata←mem[index] (old contents), state→RESP.
  - If we=1, in the same cycle write each byte lane i with sel[i]=1 to wdata[8i+7:8i]; lanes with sel[i]=0 are kept. A write with sel=0 is acked and leaves memory unchanged.
- RESP: ack←0, err←0, state→IDLE. stb/cyc are ignored in this state, so a held stb is not double-accepted.
- ack and err are never high together.
- Reset (any state, any cycle):
  - ack=0, err=0, rdata=0, init_done_out=0, clear counter=0.
  - State→CLEAR, or →IDLE when ClearOnReset=0.
  - Reset wins over a request sampled on the same edge; no write occurs.
  - Memory contents are not reset except through the clear engine.

## Timing
- A request sampled in IDLE at edge N gives ack or err high from N to N+1 for exactly one cycle, then 0 after N+1.
- rdata is valid while ack is high and holds until the next successful access.
- A write is visible to a read accepted at edge N+2 or later.
- Maximum throughput is one transaction per 2 cycles; the earliest next accept is edge N+2.
- Clear duration: init_done_out rises DepthWords cycles after the first clk_in edge with reset_in low. A request pending throughout is accepted on the first IDLE edge.
- Reset mid-CLEAR restarts the counter at 0 and takes the full DepthWords cycles again.

## Test plan
- Clear: DepthWords=16, preload array with 32'hDEADBEEF, reset → init_done_out high exactly 16 cycles after reset release; reads of all 16 words return 32'h0 with one-cycle ack each.
- Byte lanes: word at BaseAddr+4 = 32'h11223344; write wdata=32'hAABBCCDD, sel=4'b0010 → ack, rdata=32'h11223344 (old value); a following read returns 32'h1122CC44. A write with sel=4'b0000 → ack, word unchanged.
- Errors: addr=BaseAddr+2 → err pulse for one cycle with no ack. addr=BaseAddr+DepthWords*4 → err. addr=BaseAddr−4 → err. Neither case alters memory or rdata.
- Stall during clear: stb/cyc read of BaseAddr asserted right after reset → no ack until init_done_out=1, then ack exactly one cycle after the first IDLE edge.
- Back-to-back: stb held high for 6 cycles at the same address → acks on alternate cycles (3 acks), never two consecutive.
- Reset mid-operation: assert reset_in on the edge where a write is sampled → no ack, word unchanged, outputs 0. Reset at clear count 5 → clear restarts and completes DepthWords cycles after release.
